// File: rtl/maxpool_flat.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_flat
// Purpose  : 2x2/stride-2 unsigned max pooling over CH square images held in
//            external banks; optional flatten copy when MAXPOOL_FLAT_FLATTEN_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
module maxpool_flat #(
    parameter int         DW       = 20,
    parameter int         IMG_W    = 64,
    parameter int         CH       = 2,
    parameter logic [2:0] SRC_SEL0 = 3'd1,
    parameter logic [2:0] DST_SEL0 = 3'd3,
    parameter logic [2:0] FLAT_SEL = 3'd5,
    localparam int        AW       = 2 * $clog2(IMG_W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    output logic          busy,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);

    localparam int HW = $clog2(IMG_W) - 1;
    localparam int PW = 2 * HW;

    if (CH < 1 || CH > 4 || IMG_W < 4 || IMG_W > 64 || (IMG_W & (IMG_W - 1)) != 0 ||
        (int'(FLAT_SEL) >= int'(DST_SEL0) && int'(FLAT_SEL) < int'(DST_SEL0) + CH)) begin : g_bad_cfg
        $error("maxpool_flat: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LAST  = 3'd2,
        S_WPOOL = 3'd3,
        S_WFLAT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        r_state;
    logic [1:0]    r_k;
    logic [1:0]    r_kd;
    logic [1:0]    r_ch;
    logic [PW-1:0] r_pix;
    logic [DW-1:0] r_max;
    logic          r_rd_d;

    logic [DW-1:0] w_max_next;
    logic          w_last_ch;
    logic          w_last_pix;
    logic          w_advance;
    logic [1:0]    w_ch_next;
    logic [PW-1:0] w_pix_next;

    // Pixel index is {row, col} of the pooled grid; window tap k adds {k[1], k[0]}
    // as the low bit of the source row and column respectively.
    function automatic logic [AW-1:0] rd_addr(input logic [PW-1:0] pix, input logic [1:0] k);
        return {pix[PW-1:HW], k[1], pix[HW-1:0], k[0]};
    endfunction

`ifdef MAXPOOL_FLAT_FLATTEN_EN
    logic [AW-1:0] w_flat_addr;
    assign w_flat_addr = {{(AW-PW){1'b0}}, r_pix} * AW'(CH) + {{(AW-2){1'b0}}, r_ch};
    assign w_advance   = (r_state == S_WFLAT);
`else
    assign w_advance   = (r_state == S_WPOOL);
`endif

    // Read data lags the strobe by one cycle, so r_rd_d/r_kd tag the datum on cdata_rd.
    always_comb begin
        w_max_next = r_max;
        if (r_rd_d && (r_kd == 2'd0 || cdata_rd > r_max)) begin
            w_max_next = cdata_rd;
        end
        w_last_ch  = (r_ch == 2'(CH - 1));
        w_last_pix = &r_pix;
        w_ch_next  = w_last_ch ? 2'd0 : r_ch + 2'd1;
        w_pix_next = w_last_ch ? r_pix + PW'(1) : r_pix;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_k      <= 2'd0;
            r_kd     <= 2'd0;
            r_ch     <= 2'd0;
            r_pix    <= '0;
            r_max    <= '0;
            r_rd_d   <= 1'b0;
            busy     <= 1'b0;
            crd      <= 1'b0;
            cwr      <= 1'b0;
            caddr_rd <= '0;
            caddr_wr <= '0;
            cdata_wr <= '0;
            csel     <= 3'd0;
        end else begin
            r_rd_d <= crd;
            r_kd   <= r_k;
            r_max  <= w_max_next;
            case (r_state)
                S_IDLE: begin
                    if (ready) begin
                        r_state  <= S_READ;
                        busy     <= 1'b1;
                        crd      <= 1'b1;
                        csel     <= SRC_SEL0 + {1'b0, r_ch};
                        caddr_rd <= rd_addr(r_pix, 2'd0);
                        r_k      <= 2'd0;
                    end
                end
                S_READ: begin
                    if (r_k == 2'd3) begin
                        r_state <= S_LAST;
                        crd     <= 1'b0;
                    end else begin
                        r_k      <= r_k + 2'd1;
                        caddr_rd <= rd_addr(r_pix, r_k + 2'd1);
                    end
                end
                S_LAST: begin
                    r_state  <= S_WPOOL;
                    cwr      <= 1'b1;
                    csel     <= DST_SEL0 + {1'b0, r_ch};
                    caddr_wr <= AW'(r_pix);
                    cdata_wr <= w_max_next;
                end
                S_WPOOL: begin
`ifdef MAXPOOL_FLAT_FLATTEN_EN
                    r_state  <= S_WFLAT;
                    csel     <= FLAT_SEL;
                    caddr_wr <= w_flat_addr;
`endif
                end
`ifdef MAXPOOL_FLAT_FLATTEN_EN
                S_WFLAT: begin
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_advance) begin
                cwr   <= 1'b0;
                r_ch  <= w_ch_next;
                r_pix <= w_pix_next;
                r_k   <= 2'd0;
                if (w_last_ch && w_last_pix) begin
                    r_state <= S_DONE;
                end else begin
                    r_state  <= S_READ;
                    crd      <= 1'b1;
                    csel     <= SRC_SEL0 + {1'b0, w_ch_next};
                    caddr_rd <= rd_addr(w_pix_next, 2'd0);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_maxpool_flat.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxpool_flat
// Purpose  : directed self-checking bench for maxpool_flat (IMG_W=4, CH=2)
// Revision : 1.0 - initial release
// ============================================================================
module tb_maxpool_flat;

    localparam int DW    = 20;
    localparam int IMG_W = 4;
    localparam int CH    = 2;
    localparam int AW    = 4;
`ifdef MAXPOOL_FLAT_FLATTEN_EN
    localparam int PER = 7;
`else
    localparam int PER = 6;
`endif
    localparam int JOB_BUSY = PER * 4 * CH + 1;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          ready = 1'b0;
    logic          busy;
    logic          crd;
    logic          cwr;
    logic [AW-1:0] caddr_rd;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_rd = '0;
    logic [DW-1:0] cdata_wr;
    logic [2:0]    csel;

    logic [DW-1:0] src0 [16] = '{20'd5, 20'd9, 20'd1, 20'd2, 20'd9, 20'd2, 20'd3, 20'd4,
                                 20'd10, 20'd20, 20'd7, 20'd7, 20'd30, 20'd0, 20'd7, 20'd6};
    logic [DW-1:0] src1 [16] = '{20'hFFFFF, 20'h0, 20'h80000, 20'h7FFFF, 20'hFFFFF, 20'h1, 20'h0, 20'h80001,
                                 20'd0, 20'd0, 20'd11, 20'd12, 20'd0, 20'd0, 20'd13, 20'd14};
    logic [DW-1:0] exp0 [4] = '{20'd9, 20'd4, 20'd30, 20'd7};
    logic [DW-1:0] exp1 [4] = '{20'hFFFFF, 20'h80001, 20'd0, 20'd14};

    logic [DW-1:0] pool0 [16];
    logic [DW-1:0] pool1 [16];
    logic [DW-1:0] flat  [16];
    int pool_cnt0 [16];
    int pool_wr = 0, flat_wr = 0, bad_wr = 0, overlap = 0, flat_sel_seen = 0, busy_total = 0;
    int checks = 0, errors = 0;

    maxpool_flat #(
        .DW      (DW),
        .IMG_W   (IMG_W),
        .CH      (CH),
        .SRC_SEL0(3'd1),
        .DST_SEL0(3'd3),
        .FLAT_SEL(3'd5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ready   (ready),
        .busy    (busy),
        .crd     (crd),
        .caddr_rd(caddr_rd),
        .cdata_rd(cdata_rd),
        .cwr     (cwr),
        .caddr_wr(caddr_wr),
        .cdata_wr(cdata_wr),
        .csel    (csel)
    );

    always #5 clk = ~clk;

    // Bank memory model with one-cycle read latency, plus protocol monitors.
    always @(posedge clk) begin
        if (busy) busy_total <= busy_total + 1;
        if (crd && cwr) overlap <= overlap + 1;
        if (csel == 3'd5) flat_sel_seen <= flat_sel_seen + 1;
        if (crd) cdata_rd <= (csel == 3'd1) ? src0[caddr_rd] : (csel == 3'd2) ? src1[caddr_rd] : '0;
        if (cwr) begin
            if (csel == 3'd3) begin
                pool0[caddr_wr]     <= cdata_wr;
                pool_cnt0[caddr_wr] <= pool_cnt0[caddr_wr] + 1;
                pool_wr             <= pool_wr + 1;
            end else if (csel == 3'd4) begin
                pool1[caddr_wr] <= cdata_wr;
                pool_wr         <= pool_wr + 1;
            end else if (csel == 3'd5) begin
                flat[caddr_wr] <= cdata_wr;
                flat_wr        <= flat_wr + 1;
            end else begin
                bad_wr <= bad_wr + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0;
        int n;
        int low;
        for (int i = 0; i < 16; i++) pool_cnt0[i] = 0;

        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_crd", {31'd0, crd}, 0);
        chk("rst_cwr", {31'd0, cwr}, 0);
        chk("rst_caddr_rd", {28'd0, caddr_rd}, 0);
        chk("rst_caddr_wr", {28'd0, caddr_wr}, 0);
        chk("rst_cdata_wr", {12'd0, cdata_wr}, 0);
        chk("rst_csel", {29'd0, csel}, 0);
        reset = 1'b0;
        @(negedge clk);

        // First job: walk the first output step by step.
        b0 = busy_total;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("acc_busy", {31'd0, busy}, 1);
        chk("rd0_crd", {31'd0, crd}, 1);
        chk("rd0_addr", {28'd0, caddr_rd}, 0);
        chk("rd0_csel", {29'd0, csel}, 1);
        @(negedge clk);
        chk("rd1_addr", {28'd0, caddr_rd}, 1);
        @(negedge clk);
        chk("rd2_addr", {28'd0, caddr_rd}, 4);
        @(negedge clk);
        chk("rd3_addr", {28'd0, caddr_rd}, 5);
        chk("rd3_crd", {31'd0, crd}, 1);
        @(negedge clk);
        chk("last_crd", {31'd0, crd}, 0);
        chk("last_addr_hold", {28'd0, caddr_rd}, 5);
        chk("last_cwr", {31'd0, cwr}, 0);
        @(negedge clk);
        chk("wpool_cwr", {31'd0, cwr}, 1);
        chk("wpool_csel", {29'd0, csel}, 3);
        chk("wpool_addr", {28'd0, caddr_wr}, 0);
        chk("wpool_data", {12'd0, cdata_wr}, 9);
`ifdef MAXPOOL_FLAT_FLATTEN_EN
        @(negedge clk);
        chk("wflat_cwr", {31'd0, cwr}, 1);
        chk("wflat_csel", {29'd0, csel}, 5);
        chk("wflat_addr", {28'd0, caddr_wr}, 0);
        chk("wflat_data", {12'd0, cdata_wr}, 9);
`endif
        @(negedge clk);
        chk("ch1_cwr", {31'd0, cwr}, 0);
        chk("ch1_crd", {31'd0, crd}, 1);
        chk("ch1_csel", {29'd0, csel}, 2);
        chk("ch1_addr", {28'd0, caddr_rd}, 0);
        wait_idle("job1_end");
        chk("job1_busy_cycles", busy_total - b0, JOB_BUSY);
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("pool0_p%0d", p), {12'd0, pool0[p]}, {12'd0, exp0[p]});
            chk($sformatf("pool1_p%0d", p), {12'd0, pool1[p]}, {12'd0, exp1[p]});
        end
        chk("pool0_p0_writes", pool_cnt0[0], 1);
        chk("pool_writes", pool_wr, 8);
        chk("bad_bank_writes", bad_wr, 0);
        chk("rd_wr_overlap", overlap, 0);
`ifdef MAXPOOL_FLAT_FLATTEN_EN
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("flat_%0d", 2 * p), {12'd0, flat[2 * p]}, {12'd0, exp0[p]});
            chk($sformatf("flat_%0d", 2 * p + 1), {12'd0, flat[2 * p + 1]}, {12'd0, exp1[p]});
        end
        chk("flat_writes", flat_wr, 8);
`else
        chk("flat_sel_seen", flat_sel_seen, 0);
`endif

        // Reset in the middle of a job, then restart from p=0, ch=0.
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (20) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_crd", {31'd0, crd}, 0);
        chk("abort_cwr", {31'd0, cwr}, 0);
        chk("abort_caddr_rd", {28'd0, caddr_rd}, 0);
        chk("abort_csel", {29'd0, csel}, 0);
        chk("abort_keeps_pool", {12'd0, pool0[0]}, 9);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        b0 = busy_total;
        chk("restart_crd", {31'd0, crd}, 1);
        chk("restart_addr", {28'd0, caddr_rd}, 0);
        chk("restart_csel", {29'd0, csel}, 1);
        repeat (10) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        wait_idle("job2_end");
        chk("job2_busy_cycles", busy_total - b0, JOB_BUSY);
        b0 = busy_total;
        repeat (5) @(negedge clk);
        chk("no_spurious_job", busy_total - b0, 0);
        chk("job2_pool1_p3", {12'd0, pool1[3]}, 14);

        // Ready held high across DONE: back-to-back jobs.
        b0 = busy_total;
        ready = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (busy === 1'b1 && n < 400) begin @(negedge clk); n++; end
        low = 0;
        while (busy !== 1'b1 && low < 10) begin low++; @(negedge clk); end
        chk("b2b_gap", low, 1);
        ready = 1'b0;
        wait_idle("b2b_end");
        chk("b2b_busy_cycles", busy_total - b0, 2 * JOB_BUSY);
        chk("final_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
